mem_access_sequencer: RTL and testbench



---
 rtl/mem_access_sequencer_pkg.sv | 24 ++
 rtl/mem_ift.sv | 33 +++
 rtl/mem_access_sequencer_phase_timer.sv | 35 +++
 rtl/mem_access_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_sequencer_pkg.sv
// Shared types and constants for the instruction/data memory sequencer.
package mem_access_sequencer_pkg;

   localparam int MEM_SEQ_TIMEOUT = 1024;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_IF_REQ,
      ST_IF_WAIT,
      ST_DEC,
      ST_DR_REQ,
      ST_DR_WAIT,
      ST_DW_REQ,
      ST_DW_WAIT,
      ST_COMMIT,
      ST_HALT
   } mem_seq_state_t;

   // The 64-bit fetch line carries two instructions; pc[2] picks the half.
   function automatic logic [31:0] inst_select(input logic [63:0] line, input logic hi);
      return hi ? line[63:32] : line[31:0];
   endfunction

endpackage

// File: rtl/mem_ift.sv
// Valid/ready memory port: read request/reply and write request/reply channels.
interface Mem_ift #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              r_request_valid;
   logic              r_request_ready;
   logic [ADDR_W-1:0] r_request_addr;
   logic              r_reply_valid;
   logic              r_reply_ready;
   logic [DATA_W-1:0] r_reply_data;
   logic              w_request_valid;
   logic              w_request_ready;
   logic [ADDR_W-1:0] w_request_addr;
   logic [DATA_W-1:0] w_request_data;
   logic [DATA_W-1:0] w_request_mask;
   logic              w_reply_valid;
   logic              w_reply_ready;

   modport Master (
      output r_request_valid, r_request_addr, r_reply_ready,
      output w_request_valid, w_request_addr, w_request_data, w_request_mask, w_reply_ready,
      input  r_request_ready, r_reply_valid, r_reply_data,
      input  w_request_ready, w_reply_valid
   );

   modport Slave (
      input  r_request_valid, r_request_addr, r_reply_ready,
      input  w_request_valid, w_request_addr, w_request_data, w_request_mask, w_reply_ready,
      output r_request_ready, r_reply_valid, r_reply_data,
      output w_request_ready, w_reply_valid
   );
endinterface

// File: rtl/mem_access_sequencer_phase_timer.sv
// Per-phase wait timer: down-counter reloaded on every state change, expired at terminal count.
module phase_timer #(
   parameter int TIMEOUT = 1024
) (
   input  logic clk,
   input  logic rstn,
   input  logic clr,
   output logic expired
);
   localparam int               CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LOAD  = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Reload value covers the first cycle of the new phase, so zero marks its TIMEOUT-th cycle.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = LOAD;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_q <= LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/mem_access_sequencer.sv
// Multi-cycle fetch / decode-hold / optional load-or-store sequencer in front of imem and dmem.
//
//  state    | meaning
//  IDLE     | first cycle out of reset
//  IF_REQ   | imem read request outstanding
//  IF_WAIT  | waiting for imem read reply
//  DEC      | instruction held for decode, operands latched
//  DR_REQ   | dmem read request outstanding
//  DR_WAIT  | waiting for dmem read reply
//  DW_REQ   | dmem write request outstanding
//  DW_WAIT  | waiting for dmem write reply
//  COMMIT   | stall released, instruction retires
//  HALT     | phase timed out, parked until reset
module mem_access_sequencer
   import mem_access_sequencer_pkg::*;
#(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = MEM_SEQ_TIMEOUT
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [ADDR_W-1:0] pc,
   input  logic              re_mem,
   input  logic              we_mem,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_wmask,
   output logic [31:0]       inst,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              commit,
   output logic              timeout_err,
   Mem_ift.Master            imem_ift,
   Mem_ift.Master            dmem_ift
);

   mem_seq_state_t    state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] line_q, line_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] wmask_q, wmask_d;
   logic              timeout_err_q, timeout_err_d;
   logic              stall_q, stall_d;
   logic              commit_q, commit_d;
   logic              ireq_valid_q, ireq_valid_d;
   logic              irep_ready_q, irep_ready_d;
   logic              drreq_valid_q, drreq_valid_d;
   logic              drrep_ready_q, drrep_ready_d;
   logic              dwreq_valid_q, dwreq_valid_d;
   logic              dwrep_ready_q, dwrep_ready_d;
   logic              tmr_expired;
   logic              unused_ok;

   phase_timer #(.TIMEOUT(TIMEOUT)) u_phase_timer (
      .clk     (clk),
      .rstn    (rstn),
      .clr     (state_d != state_q),
      .expired (tmr_expired)
   );

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      line_d        = line_q;
      rdata_d       = rdata_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      wmask_d       = wmask_q;
      unique case (state_q)
         ST_IDLE:    state_d = ST_IF_REQ;
         ST_IF_REQ: begin
            if (imem_ift.r_request_ready) state_d = ST_IF_WAIT;
            else if (tmr_expired)         state_d = ST_HALT;
         end
         ST_IF_WAIT: begin
            if (imem_ift.r_reply_valid) begin
               line_d  = imem_ift.r_reply_data;
               state_d = ST_DEC;
            end else if (tmr_expired) begin
               state_d = ST_HALT;
            end
         end
         ST_DEC: begin
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            wmask_d = mem_wmask;
            if (re_mem)      state_d = ST_DR_REQ;
            else if (we_mem) state_d = ST_DW_REQ;
            else             state_d = ST_COMMIT;
         end
         ST_DR_REQ: begin
            if (dmem_ift.r_request_ready) state_d = ST_DR_WAIT;
            else if (tmr_expired)         state_d = ST_HALT;
         end
         ST_DR_WAIT: begin
            if (dmem_ift.r_reply_valid) begin
               rdata_d = dmem_ift.r_reply_data;
               state_d = ST_COMMIT;
            end else if (tmr_expired) begin
               state_d = ST_HALT;
            end
         end
         ST_DW_REQ: begin
            if (dmem_ift.w_request_ready) state_d = ST_DW_WAIT;
            else if (tmr_expired)         state_d = ST_HALT;
         end
         ST_DW_WAIT: begin
            if (dmem_ift.w_reply_valid) state_d = ST_COMMIT;
            else if (tmr_expired)       state_d = ST_HALT;
         end
         ST_COMMIT:  state_d = ST_IF_REQ;
         ST_HALT:    state_d = ST_HALT;
         default:    state_d = ST_HALT;
      endcase

      if ((state_d == ST_IF_REQ) && (state_q != ST_IF_REQ)) pc_d = pc;

      // Outputs are decoded from the next state so they leave the flops glitch-free.
      timeout_err_d = timeout_err_q | (state_d == ST_HALT);
      stall_d       = (state_d != ST_COMMIT);
      commit_d      = (state_d == ST_COMMIT);
      ireq_valid_d  = (state_d == ST_IF_REQ);
      irep_ready_d  = (state_d == ST_IF_WAIT);
      drreq_valid_d = (state_d == ST_DR_REQ);
      drrep_ready_d = (state_d == ST_DR_WAIT);
      dwreq_valid_d = (state_d == ST_DW_REQ);
      dwrep_ready_d = (state_d == ST_DW_WAIT);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         line_q        <= '0;
         rdata_q       <= '0;
         addr_q        <= '0;
         wdata_q       <= '0;
         wmask_q       <= '0;
         timeout_err_q <= 1'b0;
         stall_q       <= 1'b1;
         commit_q      <= 1'b0;
         ireq_valid_q  <= 1'b0;
         irep_ready_q  <= 1'b0;
         drreq_valid_q <= 1'b0;
         drrep_ready_q <= 1'b0;
         dwreq_valid_q <= 1'b0;
         dwrep_ready_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         line_q        <= line_d;
         rdata_q       <= rdata_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         wmask_q       <= wmask_d;
         timeout_err_q <= timeout_err_d;
         stall_q       <= stall_d;
         commit_q      <= commit_d;
         ireq_valid_q  <= ireq_valid_d;
         irep_ready_q  <= irep_ready_d;
         drreq_valid_q <= drreq_valid_d;
         drrep_ready_q <= drrep_ready_d;
         dwreq_valid_q <= dwreq_valid_d;
         dwrep_ready_q <= dwrep_ready_d;
      end
   end

   // A decoded load+store is a Core bug; the read path wins in hardware.
   dec_rw_exclusive: assert property (@(posedge clk) disable iff (!rstn)
      (state_q == ST_DEC) |-> !(re_mem && we_mem));

   assign inst        = inst_select(line_q, pc_q[2]);
   assign rdata       = rdata_q;
   assign stall       = stall_q;
   assign commit      = commit_q;
   assign timeout_err = timeout_err_q;

   assign imem_ift.r_request_valid = ireq_valid_q;
   assign imem_ift.r_request_addr  = {pc_q[ADDR_W-1:3], 3'b000};
   assign imem_ift.r_reply_ready   = irep_ready_q;
   assign imem_ift.w_request_valid = 1'b0;
   assign imem_ift.w_request_addr  = '0;
   assign imem_ift.w_request_data  = '0;
   assign imem_ift.w_request_mask  = '0;
   assign imem_ift.w_reply_ready   = 1'b0;

   assign dmem_ift.r_request_valid = drreq_valid_q;
   assign dmem_ift.r_request_addr  = addr_q;
   assign dmem_ift.r_reply_ready   = drrep_ready_q;
   assign dmem_ift.w_request_valid = dwreq_valid_q;
   assign dmem_ift.w_request_addr  = addr_q;
   assign dmem_ift.w_request_data  = wdata_q;
   assign dmem_ift.w_request_mask  = wmask_q;
   assign dmem_ift.w_reply_ready   = dwrep_ready_q;

   assign unused_ok = ^{pc_q[1:0], imem_ift.w_request_ready, imem_ift.w_reply_valid};

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed bench for mem_access_sequencer: fetch, load, store, reset abort and phase timeout.
module tb_mem_access_sequencer;
   import mem_access_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [63:0] pc, mem_addr, mem_wdata, mem_wmask;
   logic        re_mem, we_mem;
   logic [31:0] inst;
   logic [63:0] rdata;
   logic        stall, commit, timeout_err;
   int          n_tests = 0;
   int          n_fail  = 0;

   Mem_ift #(.ADDR_W(64), .DATA_W(64)) imem_if ();
   Mem_ift #(.ADDR_W(64), .DATA_W(64)) dmem_if ();

   mem_access_sequencer #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(16)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .pc          (pc),
      .re_mem      (re_mem),
      .we_mem      (we_mem),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wmask   (mem_wmask),
      .inst        (inst),
      .rdata       (rdata),
      .stall       (stall),
      .commit      (commit),
      .timeout_err (timeout_err),
      .imem_ift    (imem_if),
      .dmem_ift    (dmem_if)
   );

   always #5 clk = ~clk;

   logic [7:0] hs_all;
   assign hs_all = {imem_if.r_request_valid, imem_if.r_reply_ready,
                    imem_if.w_request_valid, imem_if.w_reply_ready,
                    dmem_if.r_request_valid, dmem_if.r_reply_ready,
                    dmem_if.w_request_valid, dmem_if.w_reply_ready};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic imem_zero_wait(input logic [63:0] line);
      imem_if.r_request_ready = 1'b1;
      imem_if.r_reply_valid   = 1'b1;
      imem_if.r_reply_data    = line;
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      pc = '0; re_mem = 1'b0; we_mem = 1'b0;
      mem_addr = '0; mem_wdata = '0; mem_wmask = '0;
      imem_if.r_request_ready = 1'b0; imem_if.r_reply_valid = 1'b0; imem_if.r_reply_data = '0;
      imem_if.w_request_ready = 1'b0; imem_if.w_reply_valid = 1'b0;
      dmem_if.r_request_ready = 1'b0; dmem_if.r_reply_valid = 1'b0; dmem_if.r_reply_data = '0;
      dmem_if.w_request_ready = 1'b0; dmem_if.w_reply_valid = 1'b0;
      #1 rstn = 1'b0;
      #12;
      n_tests++; if ({stall, commit, timeout_err} !== 3'b100) begin n_fail++;
         $display("FAIL reset_ctrl: got stall/commit/terr=%b want 100", {stall, commit, timeout_err}); end
      n_tests++; if (hs_all !== 8'h00) begin n_fail++;
         $display("FAIL reset_handshakes: got %b want 00000000", hs_all); end
      n_tests++; if (inst !== 32'h0 || rdata !== 64'h0) begin n_fail++;
         $display("FAIL reset_data: got inst=%h rdata=%h want 0/0", inst, rdata); end
      n_tests++; if (dmem_if.w_request_addr !== 64'h0 || dmem_if.w_request_mask !== 64'h0) begin n_fail++;
         $display("FAIL reset_latches: got addr=%h mask=%h want 0/0",
                  dmem_if.w_request_addr, dmem_if.w_request_mask); end
      pc = 64'h8;
      imem_zero_wait(64'h11111111_22222222);
      @(negedge clk) rstn = 1'b1;
      #1;
      n_tests++; if (stall !== 1'b1 || hs_all !== 8'h00) begin n_fail++;
         $display("FAIL idle_after_release: got stall=%b hs=%b want 1/0", stall, hs_all); end
   endtask

   // Starts in IDLE; ends sampled inside the COMMIT cycle.
   task automatic test_alu_fetch();
      tick();
      n_tests++; if (imem_if.r_request_valid !== 1'b1 || imem_if.r_request_addr !== 64'h8) begin n_fail++;
         $display("FAIL alu_if_req: got valid=%b raddr=%h want 1/8",
                  imem_if.r_request_valid, imem_if.r_request_addr); end
      tick();
      n_tests++; if ({imem_if.r_request_valid, imem_if.r_reply_ready} !== 2'b01) begin n_fail++;
         $display("FAIL alu_if_wait: got req_valid/rep_ready=%b want 01",
                  {imem_if.r_request_valid, imem_if.r_reply_ready}); end
      tick();
      n_tests++; if (inst !== 32'h22222222 || stall !== 1'b1 || commit !== 1'b0) begin n_fail++;
         $display("FAIL alu_dec: got inst=%h stall=%b commit=%b want 22222222/1/0", inst, stall, commit); end
      tick();
      n_tests++; if ({stall, commit} !== 2'b01) begin n_fail++;
         $display("FAIL alu_commit_cycle4: got stall/commit=%b want 01", {stall, commit}); end
   endtask

   task automatic test_inst_upper();
      pc = 64'h14;
      imem_zero_wait(64'hDEADBEEF_00A00093);
      tick();
      n_tests++; if (imem_if.r_request_addr !== 64'h10) begin n_fail++;
         $display("FAIL upper_raddr: got %h want 10", imem_if.r_request_addr); end
      for (int i = 0; i < 3; i++) begin
         n_tests++; if ({stall, commit} !== 2'b10) begin n_fail++;
            $display("FAIL upper_stall_c%0d: got stall/commit=%b want 10", i, {stall, commit}); end
         tick();
      end
      n_tests++; if ({stall, commit} !== 2'b01 || inst !== 32'hDEADBEEF) begin n_fail++;
         $display("FAIL upper_commit: got stall/commit=%b inst=%h want 01/deadbeef", {stall, commit}, inst); end
   endtask

   task automatic test_load();
      pc = 64'h20; re_mem = 1'b1; mem_addr = 64'h1000;
      imem_zero_wait(64'h00000000_00003003);
      dmem_if.r_request_ready = 1'b0; dmem_if.r_reply_valid = 1'b0;
      dmem_if.r_reply_data = 64'hCAFEF00D_12345678;
      tick(); tick(); tick();
      tick();
      re_mem = 1'b0; mem_addr = 64'hBAD;
      for (int i = 0; i < 4; i++) begin
         n_tests++; if (dmem_if.r_request_valid !== 1'b1 || dmem_if.r_request_addr !== 64'h1000 || commit !== 1'b0) begin
            n_fail++;
            $display("FAIL load_req_hold_c%0d: got valid=%b raddr=%h commit=%b want 1/1000/0",
                     i, dmem_if.r_request_valid, dmem_if.r_request_addr, commit); end
         if (i == 3) dmem_if.r_request_ready = 1'b1;
         if (i < 3) tick();
      end
      tick();
      dmem_if.r_request_ready = 1'b0;
      n_tests++; if ({dmem_if.r_request_valid, dmem_if.r_reply_ready, commit} !== 3'b010) begin n_fail++;
         $display("FAIL load_wait: got req_valid/rep_ready/commit=%b want 010",
                  {dmem_if.r_request_valid, dmem_if.r_reply_ready, commit}); end
      dmem_if.r_reply_valid = 1'b1;
      tick();
      dmem_if.r_reply_valid = 1'b0;
      n_tests++; if (commit !== 1'b1 || rdata !== 64'hCAFEF00D_12345678) begin n_fail++;
         $display("FAIL load_commit_cycle9: got commit=%b rdata=%h want 1/cafef00d12345678", commit, rdata); end
   endtask

   task automatic test_store();
      pc = 64'h24; we_mem = 1'b1; mem_addr = 64'h2000;
      mem_wdata = 64'h55; mem_wmask = 64'hFF;
      imem_zero_wait(64'h00B12023_00000013);
      dmem_if.w_request_ready = 1'b0; dmem_if.w_reply_valid = 1'b0;
      tick(); tick(); tick();
      tick();
      we_mem = 1'b0; mem_addr = 64'hBAD; mem_wdata = 64'hAA; mem_wmask = 64'h0;
      for (int i = 0; i < 3; i++) begin
         n_tests++; if ({dmem_if.w_request_valid, dmem_if.w_request_addr, dmem_if.w_request_data,
                         dmem_if.w_request_mask} !== {1'b1, 64'h2000, 64'h55, 64'hFF}) begin
            n_fail++;
            $display("FAIL store_req_hold_c%0d: got valid=%b addr=%h data=%h mask=%h want 1/2000/55/ff", i,
                     dmem_if.w_request_valid, dmem_if.w_request_addr, dmem_if.w_request_data,
                     dmem_if.w_request_mask); end
         if (i == 2) dmem_if.w_request_ready = 1'b1;
         tick();
      end
      dmem_if.w_request_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         n_tests++; if ({dmem_if.w_request_valid, dmem_if.w_reply_ready, stall, commit} !== 4'b0110) begin
            n_fail++;
            $display("FAIL store_wait_c%0d: got wvalid/wrep_ready/stall/commit=%b want 0110", i,
                     {dmem_if.w_request_valid, dmem_if.w_reply_ready, stall, commit}); end
         if (i == 1) dmem_if.w_reply_valid = 1'b1;
         tick();
      end
      dmem_if.w_reply_valid = 1'b0;
      n_tests++; if ({stall, commit} !== 2'b01) begin n_fail++;
         $display("FAIL store_commit: got stall/commit=%b want 01", {stall, commit}); end
   endtask

   task automatic test_reset_mid_read();
      pc = 64'h30; re_mem = 1'b1; mem_addr = 64'h3000;
      imem_zero_wait(64'h00000000_00002003);
      dmem_if.r_request_ready = 1'b1; dmem_if.r_reply_valid = 1'b0;
      tick(); tick(); tick();
      tick();
      re_mem = 1'b0;
      tick();
      n_tests++; if (dmem_if.r_reply_ready !== 1'b1) begin n_fail++;
         $display("FAIL midrd_in_wait: got rep_ready=%b want 1", dmem_if.r_reply_ready); end
      #1 rstn = 1'b0;
      #1;
      n_tests++; if (hs_all !== 8'h00 || stall !== 1'b1 || rdata !== 64'h0) begin n_fail++;
         $display("FAIL midrd_async_reset: got hs=%b stall=%b rdata=%h want 0/1/0", hs_all, stall, rdata); end
      pc = 64'h40;
      dmem_if.r_request_ready = 1'b0;
      imem_zero_wait(64'h00000000_00000013);
      @(negedge clk) rstn = 1'b1;
      tick();
      n_tests++; if (imem_if.r_request_valid !== 1'b1 || imem_if.r_request_addr !== 64'h40 ||
                     dmem_if.r_reply_ready !== 1'b0) begin n_fail++;
         $display("FAIL midrd_refetch: got valid=%b raddr=%h drep_ready=%b want 1/40/0",
                  imem_if.r_request_valid, imem_if.r_request_addr, dmem_if.r_reply_ready); end
      tick(); tick(); tick();
      n_tests++; if (commit !== 1'b1 || inst !== 32'h00000013) begin n_fail++;
         $display("FAIL midrd_commit: got commit=%b inst=%h want 1/00000013", commit, inst); end
   endtask

   task automatic test_timeout();
      pc = 64'h50;
      imem_if.r_request_ready = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         tick();
         n_tests++; if (imem_if.r_request_valid !== 1'b1 || timeout_err !== 1'b0) begin n_fail++;
            $display("FAIL timeout_wait_c%0d: got valid=%b terr=%b want 1/0", k,
                     imem_if.r_request_valid, timeout_err); end
      end
      tick();
      n_tests++; if (timeout_err !== 1'b1 || hs_all !== 8'h00 || stall !== 1'b1) begin n_fail++;
         $display("FAIL timeout_halt: got terr=%b hs=%b stall=%b want 1/0/1", timeout_err, hs_all, stall); end
      imem_if.r_request_ready = 1'b1;
      dmem_if.r_reply_valid = 1'b1;
      tick(); tick(); tick();
      n_tests++; if ({timeout_err, stall, commit} !== 3'b110 || hs_all !== 8'h00) begin n_fail++;
         $display("FAIL timeout_sticky: got terr/stall/commit=%b hs=%b want 110/0",
                  {timeout_err, stall, commit}, hs_all); end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100000 want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_alu_fetch();
      test_inst_upper();
      test_load();
      test_store();
      test_reset_mid_read();
      test_timeout();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
